spi_dac_streamer: RTL and testbench

Parametrised successor to the tone SPI master. It streams fixed-width sample words to a serial DAC at a programmable sample period. Samples arrive through a one-entry valid/ready buffer, and the frame shape is configurable: word width, SCLK divider, clock polarity and SYNC polarity. It sits between the tone/sample generator and the DAC pins, and adds underrun and overrun reporting, which the previous block did not have.

---
 rtl/spi_dac_streamer.sv | 180 ++++++++++++++++++
 tb/tb_spi_dac_streamer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_streamer.sv
// Serial DAC streamer: periodic tick generator, one-entry sample buffer and
// an SPI frame sequencer (SETUP / SHIFT / END) with underrun and overrun pulses.
module spi_dac_streamer #(
   parameter int   WORD_BITS   = 16,
   parameter int   CLK_DIV     = 2,
   parameter int   PERIOD_W    = 21,
   parameter logic CPOL        = 1'b0,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [PERIOD_W-1:0]  period,
   input  logic [WORD_BITS-1:0] sample_data,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 sync,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 underrun,
   output logic                 overrun
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(WORD_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_END   = 2'd3;

   logic [PERIOD_W-1:0]  r_count;
   logic                 r_hold_valid;
   logic [WORD_BITS-1:0] r_hold_data;
   logic [WORD_BITS-1:0] r_last_word;
   logic [1:0]           r_state;
   logic [DIV_W-1:0]     r_div;
   logic                 r_half;
   logic [BIT_W-1:0]     r_bit;
   // Bits still to be sent after the one currently on mosi, MSB aligned.
   logic [WORD_BITS-1:0] r_shift;
   logic                 r_sync;
   logic                 r_sclk;
   logic                 r_mosi;
   logic                 r_frame_done;

   logic [PERIOD_W-1:0]  w_period_m1;
   logic                 w_tick;
   logic                 w_idle;
   logic                 w_start;
   logic                 w_consume;
   logic                 w_capture;
   logic [WORD_BITS-1:0] w_load_word;

   assign w_period_m1 = period - 1'b1;
   // ">=" rather than "==" so that shrinking the period never skips a tick.
   assign w_tick      = !rst && enable && (period != '0) && (r_count >= w_period_m1);
   assign w_idle      = (r_state == S_IDLE);
   assign w_start     = w_tick && w_idle;
   assign w_consume   = w_start && r_hold_valid;
   assign w_capture   = sample_valid && !r_hold_valid;
   // An empty buffer at tick time repeats the previous word.
   assign w_load_word = r_hold_valid ? r_hold_data : r_last_word;

   assign sample_ready = ~r_hold_valid;
   assign busy         = !w_idle;
   assign underrun     = w_start && !r_hold_valid;
   assign overrun      = w_tick && !w_idle;
   assign sync         = r_sync;
   assign sclk         = r_sclk;
   assign mosi         = r_mosi;
   assign frame_done   = r_frame_done;

   // Sample-period counter: free-runs while enabled, wraps on each tick.
   always_ff @(posedge clk) begin
      if (rst || !enable || (period == '0)) begin
         r_count <= '0;
      end else if (w_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   // One-entry holding buffer; capture and consume are mutually exclusive.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
         r_last_word  <= '0;
      end else if (w_capture) begin
         r_hold_valid <= 1'b1;
         r_hold_data  <= sample_data;
      end else if (w_consume) begin
         r_hold_valid <= 1'b0;
         r_last_word  <= r_hold_data;
      end
   end

   // Frame sequencer; sync/sclk/mosi are registered with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_div        <= '0;
         r_half       <= 1'b0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_sync       <= ~SYNC_ACTIVE;
         r_sclk       <= CPOL;
         r_mosi       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_SETUP;
                  r_div   <= '0;
                  r_shift <= {w_load_word[WORD_BITS-2:0], 1'b0};
                  r_sync  <= SYNC_ACTIVE;
                  r_sclk  <= CPOL;
                  r_mosi  <= w_load_word[WORD_BITS-1];
               end
            end
            S_SETUP: begin
               if (r_div == DIV_LAST) begin
                  r_state <= S_SHIFT;
                  r_div   <= '0;
                  r_half  <= 1'b0;
                  r_bit   <= '0;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_SHIFT: begin
               if (r_div == DIV_LAST) begin
                  r_div <= '0;
                  if (!r_half) begin
                     // Mid-bit edge: the slave samples here.
                     r_half <= 1'b1;
                     r_sclk <= ~CPOL;
                  end else if (r_bit == BIT_LAST) begin
                     r_state      <= S_END;
                     r_half       <= 1'b0;
                     r_sclk       <= CPOL;
                     r_sync       <= ~SYNC_ACTIVE;
                     r_mosi       <= 1'b0;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_half  <= 1'b0;
                     r_sclk  <= CPOL;
                     r_mosi  <= r_shift[WORD_BITS-1];
                     r_shift <= {r_shift[WORD_BITS-2:0], 1'b0};
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            S_END: begin
               if (r_div == DIV_LAST) begin
                  r_state <= S_IDLE;
                  r_div   <= '0;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_dac_streamer.sv
// Bench for spi_dac_streamer: two instances (16-bit/div 2/CPOL 0/sync low and
// 8-bit/div 1/CPOL 1/sync high) checked every cycle against a frame-position model.
`timescale 1ns/1ps
module tb_spi_dac_streamer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en;
   logic [20:0] per;
   logic        valid;
   logic [15:0] data0;
   logic [7:0]  data1;

   logic [1:0] a_rdy, a_sync, a_sclk, a_mosi, a_busy, a_fd, a_und, a_ovr;

   spi_dac_streamer #(.WORD_BITS(16), .CLK_DIV(2), .PERIOD_W(21), .CPOL(1'b0), .SYNC_ACTIVE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .enable(en), .period(per), .sample_data(data0), .sample_valid(valid),
      .sample_ready(a_rdy[0]), .sync(a_sync[0]), .sclk(a_sclk[0]), .mosi(a_mosi[0]), .busy(a_busy[0]),
      .frame_done(a_fd[0]), .underrun(a_und[0]), .overrun(a_ovr[0]));

   spi_dac_streamer #(.WORD_BITS(8), .CLK_DIV(1), .PERIOD_W(21), .CPOL(1'b1), .SYNC_ACTIVE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .enable(en), .period(per), .sample_data(data1), .sample_valid(valid),
      .sample_ready(a_rdy[1]), .sync(a_sync[1]), .sclk(a_sclk[1]), .mosi(a_mosi[1]), .busy(a_busy[1]),
      .frame_done(a_fd[1]), .underrun(a_und[1]), .overrun(a_ovr[1]));

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, act, exp);
   endtask

   // Instance shapes
   function automatic int f_wb(input int d);   return (d == 0) ? 16 : 8; endfunction
   function automatic int f_div(input int d);  return (d == 0) ? 2 : 1;  endfunction
   function automatic bit f_cpol(input int d); return (d == 0) ? 1'b0 : 1'b1; endfunction
   function automatic bit f_sa(input int d);   return (d == 0) ? 1'b0 : 1'b1; endfunction
   function automatic int f_len(input int d);  return f_div(d) * (2 * f_wb(d) + 2); endfunction

   // Model: counter, buffer, and frame position (cycles since the first SETUP cycle)
   int          m_cnt [2];
   bit          m_hv  [2];
   logic [15:0] m_hd  [2];
   logic [15:0] m_last[2];
   logic [15:0] m_fw  [2];
   bit          m_act [2];
   int          m_pos [2];

   function automatic bit m_tick(input int d);
      return !rst && en && (per != 0) && (m_cnt[d] >= int'(per) - 1);
   endfunction

   always @(posedge clk) begin
      bit tk, was_busy, was_hv;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_cnt[d] = 0; m_hv[d] = 0; m_hd[d] = 0; m_last[d] = 0;
            m_fw[d] = 0; m_act[d] = 0; m_pos[d] = 0;
         end else begin
            tk = m_tick(d);
            was_busy = m_act[d];
            was_hv = m_hv[d];
            if (m_act[d]) begin
               m_pos[d]++;
               if (m_pos[d] >= f_len(d)) m_act[d] = 0;
            end
            if (tk && !was_busy) begin
               m_act[d] = 1; m_pos[d] = 0;
               m_fw[d] = was_hv ? m_hd[d] : m_last[d];
               if (was_hv) begin m_last[d] = m_hd[d]; m_hv[d] = 0; end
            end
            if (valid && !was_hv) begin
               m_hv[d] = 1;
               m_hd[d] = (d == 0) ? data0 : {8'h00, data1};
            end
            if (!en || per == 0 || tk) m_cnt[d] = 0;
            else m_cnt[d]++;
         end
      end
   end

   // Observation: receiver and event statistics, written only here
   int          n_sync[2], n_lead[2], n_fd[2], n_und[2], n_ovr[2];
   int          rx_n[2], st_n[2];
   logic [15:0] rx_sr[2];
   logic [15:0] rx_w[2][0:1023];
   int          st_c[2][0:1023];
   bit          pv_sa[2], pv_sclk[2], pv_busy[2];

   // Per-cycle compare against the model, then update the receiver.
   always @(negedge clk) begin
      int p, q, b, dv, wb;
      bit es, ec, em, sa_now;
      if (cyc > 0) begin
         for (int d = 0; d < 2; d++) begin
            dv = f_div(d); wb = f_wb(d);
            es = !f_sa(d); ec = f_cpol(d); em = 1'b0; p = m_pos[d];
            if (m_act[d]) begin
               if (p < dv) begin
                  es = f_sa(d); em = m_fw[d][wb-1];
               end else if (p < dv * (2 * wb + 1)) begin
                  q = p - dv; b = q / (2 * dv);
                  es = f_sa(d);
                  ec = ((q % (2 * dv)) >= dv) ? !f_cpol(d) : f_cpol(d);
                  em = m_fw[d][wb-1-b];
               end
            end
            chk("sync", d, a_sync[d], es);
            chk("sclk", d, a_sclk[d], ec);
            chk("mosi", d, a_mosi[d], em);
            chk("busy", d, a_busy[d], m_act[d]);
            chk("frame_done", d, a_fd[d], m_act[d] && (p == f_len(d) - dv));
            chk("underrun", d, a_und[d], m_tick(d) && !m_act[d] && !m_hv[d]);
            chk("overrun", d, a_ovr[d], m_tick(d) && m_act[d]);
            chk("sample_ready", d, a_rdy[d], !m_hv[d]);

            sa_now = (a_sync[d] == f_sa(d));
            if (sa_now) n_sync[d]++;
            if (sa_now && !pv_sa[d]) rx_sr[d] = 16'h0;
            if (sa_now && a_sclk[d] != f_cpol(d) && pv_sclk[d] == f_cpol(d)) begin
               rx_sr[d] = {rx_sr[d][14:0], a_mosi[d]};
               n_lead[d]++;
            end
            if (!sa_now && pv_sa[d]) begin
               if (rx_n[d] < 1024) rx_w[d][rx_n[d]] = rx_sr[d];
               rx_n[d]++;
            end
            if (a_busy[d] && !pv_busy[d]) begin
               if (st_n[d] < 1024) st_c[d][st_n[d]] = cyc;
               st_n[d]++;
            end
            if (a_fd[d])  n_fd[d]++;
            if (a_und[d]) n_und[d]++;
            if (a_ovr[d]) n_ovr[d]++;
            pv_sa[d] = sa_now; pv_sclk[d] = a_sclk[d]; pv_busy[d] = a_busy[d];
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [15:0] w0, input logic [7:0] w1);
      valid = 1'b1; data0 = w0; data1 = w1;
      for (int i = 0; i < 1000 && !a_rdy[0]; i++) step(1);
      if (!a_rdy[0]) chk("send_timeout", 0, a_rdy[0], 1);
      step(1);
      valid = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e_cyc, s_sync[2], s_lead[2], s_fd[2], s_und[2], s_ovr[2], s_rx[2], s_st[2];
      rst = 1'b1; en = 1'b0; per = '0; valid = 1'b0; data0 = '0; data1 = '0;
      step(3);
      rst = 1'b0;
      step(1);
      chk("rst_sync", 0, a_sync[0], 1);
      chk("rst_sync", 1, a_sync[1], 0);
      chk("rst_sclk", 1, a_sclk[1], 1);
      chk("rst_ready", 0, a_rdy[0], 1);
      chk("rst_busy", 0, a_busy[0], 0);

      // One sample, period 100
      for (int d = 0; d < 2; d++) begin
         s_sync[d] = n_sync[d]; s_lead[d] = n_lead[d]; s_fd[d] = n_fd[d];
         s_rx[d] = rx_n[d]; s_st[d] = st_n[d];
      end
      per = 21'd100; en = 1'b1; e_cyc = cyc;
      send(16'hA5C3, 8'h81);
      step(180);
      chk("t1_start_lat", 0, st_c[0][s_st[0]] - e_cyc, 100);
      chk("t1_start_lat", 1, st_c[1][s_st[1]] - e_cyc, 100);
      chk("t1_sync_cycles", 0, n_sync[0] - s_sync[0], 66);
      chk("t1_sync_cycles", 1, n_sync[1] - s_sync[1], 17);
      chk("t1_sclk_edges", 0, n_lead[0] - s_lead[0], 16);
      chk("t1_sclk_edges", 1, n_lead[1] - s_lead[1], 8);
      chk("t1_word", 0, rx_w[0][s_rx[0]], 16'hA5C3);
      chk("t1_word", 1, rx_w[1][s_rx[1]], 16'h0081);
      chk("t1_frame_done", 0, n_fd[0] - s_fd[0], 1);
      chk("t1_ready", 0, a_rdy[0], 1);

      // Two queued samples, then starvation
      for (int d = 0; d < 2; d++) begin s_und[d] = n_und[d]; s_rx[d] = rx_n[d]; s_st[d] = st_n[d]; end
      send(16'h1111, 8'h11);
      send(16'h2222, 8'h22);
      step(180);
      chk("t2_word_a", 0, rx_w[0][s_rx[0]], 16'h1111);
      chk("t2_word_b", 0, rx_w[0][s_rx[0]+1], 16'h2222);
      chk("t2_word_b", 1, rx_w[1][s_rx[1]+1], 16'h0022);
      chk("t2_gap", 0, st_c[0][s_st[0]+1] - st_c[0][s_st[0]], 100);
      chk("t2_underruns", 0, n_und[0] - s_und[0], 0);
      for (int d = 0; d < 2; d++) begin s_und[d] = n_und[d]; s_rx[d] = rx_n[d]; end
      step(200);
      chk("t3_resend_a", 0, rx_w[0][s_rx[0]], 16'h2222);
      chk("t3_resend_b", 0, rx_w[0][s_rx[0]+1], 16'h2222);
      chk("t3_resend_b", 1, rx_w[1][s_rx[1]+1], 16'h0022);
      chk("t3_underruns", 0, n_und[0] - s_und[0], 2);
      chk("t3_underruns", 1, n_und[1] - s_und[1], 2);

      // Period shorter than the 16-bit frame, buffer kept full
      for (int d = 0; d < 2; d++) begin s_ovr[d] = n_ovr[d]; s_st[d] = st_n[d]; end
      per = 21'd50; valid = 1'b1;
      for (int i = 0; i < 420; i++) begin
         data0 = 16'($urandom); data1 = 8'($urandom);
         step(1);
      end
      valid = 1'b0;
      chk("t4_nstarts", 0, (st_n[0] - s_st[0]) >= 3, 1);
      for (int j = s_st[0] + 1; j < st_n[0] && j < 1024; j++)
         chk("t4_gap", 0, st_c[0][j] - st_c[0][j-1], 100);
      for (int j = s_st[1] + 1; j < st_n[1] && j < 1024; j++)
         chk("t4_gap", 1, st_c[1][j] - st_c[1][j-1], 50);
      chk("t4_overrun_seen", 0, (n_ovr[0] - s_ovr[0]) > 0, 1);
      chk("t4_overruns", 1, n_ovr[1] - s_ovr[1], 0);

      // Reset during bit 5 of a frame, with the buffer refilled
      per = 21'd100;
      for (int i = 0; i < 200 && a_busy[0]; i++) step(1);
      for (int i = 0; i < 300 && !a_busy[0]; i++) step(1);
      chk("t5_busy_wait", 0, a_busy[0], 1);
      valid = 1'b1; data0 = 16'h1234; data1 = 8'h34;
      step(1);
      valid = 1'b0;
      chk("t5_buffer_full", 0, a_rdy[0], 0);
      step(21);
      s_fd[0] = n_fd[0];
      rst = 1'b1;
      step(1);
      chk("t5_sync", 0, a_sync[0], 1);
      chk("t5_sclk", 0, a_sclk[0], 0);
      chk("t5_busy", 0, a_busy[0], 0);
      chk("t5_ready", 0, a_rdy[0], 1);
      chk("t5_sync", 1, a_sync[1], 0);
      chk("t5_sclk", 1, a_sclk[1], 1);
      rst = 1'b0;
      step(60);
      chk("t5_no_frame_done", 0, n_fd[0] - s_fd[0], 0);

      // Randomized traffic
      en = 1'b1;
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            case ($urandom_range(0, 4))
               0:       per = '0;
               1:       per = 21'($urandom_range(1, 3));
               2:       per = 21'($urandom_range(4, 40));
               default: per = 21'($urandom_range(41, 200));
            endcase
         end
         if ($urandom_range(0, 149) == 0) en = !en;
         rst   = ($urandom_range(0, 699) == 0);
         valid = ($urandom_range(0, 3) != 0);
         data0 = 16'($urandom);
         data1 = 8'($urandom);
         step(1);
      end
      rst = 1'b0; valid = 1'b0;
      step(5);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
